// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the tiny5 data memory responder.
// Access sizes, responder FSM states and the store byte-mask helper live here.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'b00,
    MEM_ACCESS_HALF = 2'b01,
    MEM_ACCESS_WORD = 2'b10
  } mem_access_size_t;

  localparam logic [1:0] MEM_ACCESS_SIZE_RESERVED = 2'b11;

  typedef enum logic [1:0] {
    MEM_RESP_IDLE = 2'd0,
    MEM_RESP_WAIT = 2'd1,
    MEM_RESP_RESP = 2'd2
  } mem_responder_state_t;

  // Byte lanes touched by a store; the reserved size touches nothing.
  function automatic logic [3:0] mem_byte_mask(input mem_access_size_t size, input logic [1:0] lane);
    case (size)
      MEM_ACCESS_BYTE: return 4'b0001 << lane;
      MEM_ACCESS_HALF: return 4'b0011 << {lane[1], 1'b0};
      MEM_ACCESS_WORD: return 4'b1111;
      default:         return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_responder_mem_lane_align.sv
// Combinational lane steering between right-aligned core data and the 32-bit RAM word.
// Stores are replicated across lanes and masked; loads are extracted and zero-extended.
module mem_lane_align
  import data_memory_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_mask,
  output logic [31:0] wr_data_rep,
  output logic [31:0] rd_data
);

  assign byte_mask = mem_byte_mask(mem_access_size_t'(size), lane);

  always_comb begin
    wr_data_rep = wr_data;
    rd_data     = '0;
    case (size)
      MEM_ACCESS_BYTE: begin
        wr_data_rep = {4{wr_data[7:0]}};
        rd_data     = {24'b0, rd_word[{lane, 3'b000} +: 8]};
      end
      MEM_ACCESS_HALF: begin
        wr_data_rep = {2{wr_data[15:0]}};
        rd_data     = {16'b0, rd_word[{lane[1], 4'b0000} +: 16]};
      end
      MEM_ACCESS_WORD: begin
        rd_data = rd_word;
      end
      default: begin
        rd_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the tiny5 memory port: one outstanding request, fixed latency,
// sizing/alignment/error handling in front of a word-organised on-chip RAM.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wr_data_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rd_data_o,
  output logic        resp_error_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_responder_state_t state;
  logic [3:0]  count;
  logic        cap_wr;
  logic [31:0] cap_addr;
  logic [1:0]  cap_size;
  logic [31:0] cap_data;
  logic [31:0] ram [DEPTH_WORDS];

  logic        from_idle;
  logic        accept;
  logic        enter_resp;
  logic        op_wr;
  logic [31:0] op_addr;
  logic [1:0]  op_size;
  logic [31:0] op_data;
  logic [IDX_W-1:0] op_idx;
  logic        op_err;
  logic [3:0]  byte_mask;
  logic [31:0] wr_data_rep;
  logic [31:0] rd_aligned;

  assign from_idle   = (state == MEM_RESP_IDLE);
  assign req_ready_o = from_idle && !reset_i;
  assign accept      = req_valid_i && req_ready_o;

  // With LATENCY=1 the access completes on the acceptance edge, so the live request
  // feeds the datapath in IDLE and the captured copy feeds it while waiting.
  assign op_wr   = from_idle ? req_wr_i      : cap_wr;
  assign op_addr = from_idle ? req_addr_i    : cap_addr;
  assign op_size = from_idle ? req_size_i    : cap_size;
  assign op_data = from_idle ? req_wr_data_i : cap_data;
  assign op_idx  = op_addr[IDX_W+1:2];

  // The counter is loaded with LATENCY-1 and RESP is entered on the edge it reaches zero.
  assign enter_resp = (from_idle && accept && (LATENCY == 1)) ||
                      ((state == MEM_RESP_WAIT) && (count == 4'd1));

  assign op_err = (op_size == MEM_ACCESS_SIZE_RESERVED) ||
                  ((op_size == MEM_ACCESS_HALF) && op_addr[0]) ||
                  ((op_size == MEM_ACCESS_WORD) && (op_addr[1:0] != 2'b00)) ||
                  ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));

  mem_lane_align u_lane_align (
    .size        (op_size),
    .lane        (op_addr[1:0]),
    .wr_data     (op_data),
    .rd_word     (ram[op_idx]),
    .byte_mask   (byte_mask),
    .wr_data_rep (wr_data_rep),
    .rd_data     (rd_aligned)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= MEM_RESP_IDLE;
      count          <= '0;
      resp_valid_o   <= 1'b0;
      resp_rd_data_o <= '0;
      resp_error_o   <= 1'b0;
    end else if (enter_resp) begin
      state          <= MEM_RESP_RESP;
      resp_valid_o   <= 1'b1;
      resp_error_o   <= op_err;
      resp_rd_data_o <= (op_err || op_wr) ? 32'h0 : rd_aligned;
    end else begin
      case (state)
        MEM_RESP_IDLE: begin
          if (accept) begin
            state <= MEM_RESP_WAIT;
            count <= 4'(LATENCY - 1);
          end
        end
        MEM_RESP_WAIT: count <= count - 4'd1;
        MEM_RESP_RESP: begin
          if (resp_ready_i) begin
            state        <= MEM_RESP_IDLE;
            resp_valid_o <= 1'b0;
          end
        end
        default: state <= MEM_RESP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      cap_wr   <= req_wr_i;
      cap_addr <= req_addr_i;
      cap_size <= req_size_i;
      cap_data <= req_wr_data_i;
    end
  end

  // RAM is never cleared; a reset on the commit edge drops a pending store.
  always_ff @(posedge clk_i) begin
    if (!reset_i && enter_resp && op_wr && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_mask[b]) ram[op_idx][8*b +: 8] <= wr_data_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a LATENCY=2 instance for the main scenarios
// and a LATENCY=1 instance for back-to-back throughput, both checked against a byte-level model.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int TB_DEPTH = 64;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } req_t;

  logic clk = 1'b0;
  logic reset;

  logic        req_valid, req_ready, req_wr, resp_valid, resp_ready, resp_error;
  logic [31:0] req_addr, req_wr_data, resp_rd_data;
  logic [1:0]  req_size;

  logic        req_valid_l1, req_ready_l1, req_wr_l1, resp_valid_l1, resp_ready_l1, resp_error_l1;
  logic [31:0] req_addr_l1, req_wr_data_l1, resp_rd_data_l1;
  logic [1:0]  req_size_l1;

  logic [31:0] mdl [2][TB_DEPTH];
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(TB_DEPTH), .LATENCY(2)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wr_data_i(req_wr_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rd_data_o(resp_rd_data), .resp_error_o(resp_error)
  );

  data_memory_responder #(.DEPTH_WORDS(TB_DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid_l1), .req_ready_o(req_ready_l1), .req_wr_i(req_wr_l1),
    .req_addr_i(req_addr_l1), .req_size_i(req_size_l1), .req_wr_data_i(req_wr_data_l1),
    .resp_valid_o(resp_valid_l1), .resp_ready_i(resp_ready_l1),
    .resp_rd_data_o(resp_rd_data_l1), .resp_error_o(resp_error_l1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Byte-by-byte reference: walks the addressed bytes rather than using lane masks.
  task automatic modelAccess(input int d, input req_t r, output exp_t e);
    int nbytes;
    int ba;
    e.rd  = '0;
    e.err = 1'b0;
    nbytes = (r.size == 2'b00) ? 1 : (r.size == 2'b01) ? 2 : 4;
    if (r.size == 2'b11) e.err = 1'b1;
    else if ((r.addr % nbytes) != 0) e.err = 1'b1;
    else if ((r.addr / 4) >= TB_DEPTH) e.err = 1'b1;
    else begin
      for (int i = 0; i < nbytes; i++) begin
        ba = int'(r.addr) + i;
        if (r.wr) mdl[d][ba/4][8*(ba%4) +: 8] = r.data[8*i +: 8];
        else e.rd[8*i +: 8] = mdl[d][ba/4][8*(ba%4) +: 8];
      end
    end
  endtask

  // Drive one request into the LATENCY=2 instance, check latency and payload,
  // optionally hold backpressure for some cycles while a stray request is offered.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] data, input int hold);
    req_t r;
    exp_t e;
    int edges;
    string tag;
    r = '{wr: wr, addr: addr, size: size, data: data};
    modelAccess(0, r, e);
    exp_q0.push_back(e);
    tag = $sformatf("%s@%0h", wr ? "st" : "ld", addr);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_size = size; req_wr_data = data;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!req_ready) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 1;
    while (!resp_valid && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'd2);
    e = exp_q0.pop_front();
    checkOutput({tag, "_rd_data"}, resp_rd_data, e.rd);
    checkOutput({tag, "_error"}, {31'b0, resp_error}, {31'b0, e.err});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h10; req_size = 2'b10; req_wr_data = 32'h12345678;
      @(posedge clk); #1;
      checkOutput({tag, "_bp_valid"}, {31'b0, resp_valid}, 32'd1);
      checkOutput({tag, "_bp_data"}, resp_rd_data, e.rd);
      checkOutput({tag, "_bp_req_ready"}, {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput({tag, "_resp_cleared"}, {31'b0, resp_valid}, 32'd0);
    checkOutput({tag, "_ready_next"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic popL1();
    exp_t e;
    if (exp_q1.size() == 0) begin
      checkOutput("l1_unexpected_resp", 32'd1, 32'd0);
    end else begin
      e = exp_q1.pop_front();
      checkOutput("l1_rd_data", resp_rd_data_l1, e.rd);
      checkOutput("l1_error", {31'b0, resp_error_l1}, {31'b0, e.err});
    end
  endtask

  task automatic driveL1(input req_t r);
    exp_t e;
    modelAccess(1, r, e);
    exp_q1.push_back(e);
    req_valid_l1 = 1'b1; req_wr_l1 = r.wr; req_addr_l1 = r.addr;
    req_size_l1 = r.size; req_wr_data_l1 = r.data;
  endtask

  initial begin
    req_t l1_reqs[7];
    int k, cyc, last_acc;
    logic acc;

    reset = 1'b1;
    req_valid = 0; req_wr = 0; req_addr = 0; req_size = 0; req_wr_data = 0; resp_ready = 0;
    req_valid_l1 = 0; req_wr_l1 = 0; req_addr_l1 = 0; req_size_l1 = 0; req_wr_data_l1 = 0;
    resp_ready_l1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_rd_data", resp_rd_data, 32'd0);
    checkOutput("rst_error", {31'b0, resp_error}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready_after", {31'b0, req_ready}, 32'd1);

    $display("[TB] word store then sub-word loads");
    applyStimulus(1'b1, 32'h10, MEM_ACCESS_WORD, 32'hDEADBEEF, 0);
    applyStimulus(1'b0, 32'h11, MEM_ACCESS_BYTE, 32'h0, 0);
    applyStimulus(1'b0, 32'h12, MEM_ACCESS_HALF, 32'h0, 0);
    applyStimulus(1'b0, 32'h10, MEM_ACCESS_WORD, 32'h0, 0);

    $display("[TB] byte merge");
    applyStimulus(1'b1, 32'h20, MEM_ACCESS_WORD, 32'h11223344, 0);
    applyStimulus(1'b1, 32'h23, MEM_ACCESS_BYTE, 32'hFFFFFFAA, 0);
    applyStimulus(1'b0, 32'h20, MEM_ACCESS_WORD, 32'h0, 0);

    $display("[TB] error requests and boundary word");
    applyStimulus(1'b1, 32'h4, MEM_ACCESS_WORD, 32'h01020304, 0);
    applyStimulus(1'b0, 32'h5, MEM_ACCESS_HALF, 32'h0, 0);
    applyStimulus(1'b1, 32'h6, MEM_ACCESS_WORD, 32'hFFFFFFFF, 0);
    applyStimulus(1'b0, 32'(4 * TB_DEPTH), MEM_ACCESS_WORD, 32'h0, 0);
    applyStimulus(1'b1, 32'h20, MEM_ACCESS_SIZE_RESERVED, 32'h99999999, 0);
    applyStimulus(1'b0, 32'h4, MEM_ACCESS_WORD, 32'h0, 0);
    applyStimulus(1'b0, 32'h20, MEM_ACCESS_WORD, 32'h0, 0);
    applyStimulus(1'b1, 32'(4 * TB_DEPTH - 4), MEM_ACCESS_WORD, 32'h5A5AC3C3, 0);
    applyStimulus(1'b0, 32'(4 * TB_DEPTH - 2), MEM_ACCESS_HALF, 32'h0, 0);

    $display("[TB] backpressure with stray request");
    applyStimulus(1'b0, 32'h10, MEM_ACCESS_WORD, 32'h0, 5);
    applyStimulus(1'b0, 32'h10, MEM_ACCESS_WORD, 32'h0, 0);

    $display("[TB] reset while a store waits");
    applyStimulus(1'b1, 32'h30, MEM_ACCESS_WORD, 32'hCAFEF00D, 0);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h30; req_size = MEM_ACCESS_WORD; req_wr_data = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_wait_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_wait_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_wait_rd_data", resp_rd_data, 32'd0);
    checkOutput("rst_wait_error", {31'b0, resp_error}, 32'd0);
    checkOutput("rst_wait_ready_after", {31'b0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wait_no_stray_resp", {31'b0, resp_valid}, 32'd0);
    applyStimulus(1'b0, 32'h30, MEM_ACCESS_WORD, 32'h0, 0);

    $display("[TB] LATENCY=1 back-to-back");
    l1_reqs[0] = '{wr: 1'b1, addr: 32'h8, size: MEM_ACCESS_WORD, data: 32'hA5A50F0F};
    l1_reqs[1] = '{wr: 1'b1, addr: 32'hA, size: MEM_ACCESS_HALF, data: 32'h0000BEEF};
    l1_reqs[2] = '{wr: 1'b0, addr: 32'h8, size: MEM_ACCESS_WORD, data: 32'h0};
    l1_reqs[3] = '{wr: 1'b0, addr: 32'hB, size: MEM_ACCESS_BYTE, data: 32'h0};
    l1_reqs[4] = '{wr: 1'b1, addr: 32'h8, size: MEM_ACCESS_BYTE, data: 32'h00000077};
    l1_reqs[5] = '{wr: 1'b0, addr: 32'h8, size: MEM_ACCESS_HALF, data: 32'h0};
    l1_reqs[6] = '{wr: 1'b0, addr: 32'h9, size: MEM_ACCESS_WORD, data: 32'h0};
    k = 0; cyc = 0; last_acc = -1;
    driveL1(l1_reqs[0]);
    while (k < 7 && cyc < 100) begin
      acc = req_ready_l1;
      if (resp_valid_l1) popL1();
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (last_acc >= 0) checkOutput("l1_accept_spacing", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
        k++;
        if (k < 7) driveL1(l1_reqs[k]);
        else req_valid_l1 = 1'b0;
      end
    end
    if (k < 7) checkOutput("l1_accept_timeout", 32'(k), 32'd7);
    for (int i = 0; i < 5 && exp_q1.size() > 0; i++) begin
      if (resp_valid_l1) popL1();
      @(posedge clk); #1;
    end
    checkOutput("l1_queue_empty", 32'(exp_q1.size()), 32'd0);
    checkOutput("l2_queue_empty", 32'(exp_q0.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
